// File: rtl/key_expander.sv
// key_expander
//   Sequential AES-128 key expansion controller. A cipher key is accepted
//   through a valid/ready handshake. One key_schedule round is computed per
//   cycle, with rcon generated internally. All NUM_ROUNDS+1 round keys are
//   stored in a bank that the round datapath reads by index through a
//   registered read port.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous reset, active-high
//   key_in     : 128-bit cipher key; byte i at [8i+7:8i], word i at [32i+31:32i]
//   key_valid  : key_in valid; the key loads when key_valid && key_ready
//   key_ready  : controller can accept a new key (IDLE or DONE)
//   busy       : expansion in progress
//   keys_valid : every bank entry holds a round key of the current key
//   rd_idx     : round key index 0..10; 11..15 read as zero
//   rd_key     : bank[rd_idx], one cycle after rd_idx is presented
module key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam int DEPTH = NUM_ROUNDS + 1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       r_state;
  logic         r_key_ready;
  logic         r_busy;
  logic         r_keys_valid;
  logic [3:0]   r_cnt;
  logic [7:0]   r_rcon;
  logic [127:0] r_prev;
  logic [127:0] r_bank [DEPTH];
  logic [127:0] r_rd_key;

  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [127:0] w_next_key;
  logic [7:0]   w_rcon_next;
  logic [127:0] w_rd_sel;

  // RotWord of the last word: byte 0 sits in the low bits, so rotating the
  // byte order left is a rotate right by 8 bits of the packed word.
  assign w_rot = {r_prev[103:96], r_prev[127:104]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    assign w_sub[8*gi +: 8] = SBOX[w_rot[8*gi +: 8]];
  end

  assign w_temp = w_sub ^ {24'h0, r_rcon};

  // Each new word is the temp word XORed with all previous-key words up to
  // and including the same position (unrolled to keep the chain acyclic).
  assign w_next_key[31:0]   = w_temp ^ r_prev[31:0];
  assign w_next_key[63:32]  = w_temp ^ r_prev[31:0] ^ r_prev[63:32];
  assign w_next_key[95:64]  = w_temp ^ r_prev[31:0] ^ r_prev[63:32] ^ r_prev[95:64];
  assign w_next_key[127:96] = w_temp ^ r_prev[31:0] ^ r_prev[63:32] ^ r_prev[95:64]
                              ^ r_prev[127:96];

  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // Controller: the key_schedule input is always the r_prev flop, which
  // mirrors the bank entry written on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_cnt        <= 4'd0;
      r_rcon       <= 8'h01;
      r_prev       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (key_valid) begin
            r_bank[0]    <= key_in;
            r_prev       <= key_in;
            r_cnt        <= 4'd1;
            r_rcon       <= 8'h01;
            r_state      <= EXPAND;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          for (int i = 1; i < DEPTH; i++) begin
            if (r_cnt == 4'(i)) begin
              r_bank[i] <= w_next_key;
            end
          end
          r_prev <= w_next_key;
          r_cnt  <= r_cnt + 4'd1;
          r_rcon <= w_rcon_next;
          if (r_cnt == 4'(NUM_ROUNDS)) begin
            r_state      <= DONE;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_key_ready  <= 1'b1;
          r_busy       <= 1'b0;
          r_keys_valid <= 1'b0;
        end
      endcase
    end
  end

  // Indices past the last round key fall through to zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == 4'(i)) begin
        w_rd_sel = r_bank[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_key <= '0;
    end else begin
      r_rd_key <= w_rd_sel;
    end
  end

  assign key_ready  = r_key_ready;
  assign busy       = r_busy;
  assign keys_valid = r_keys_valid;
  assign rd_key     = r_rd_key;

endmodule

// File: tb/tb_key_expander.sv
// tb_key_expander
//   Randomized bench for key_expander. The reference builds the FIPS-197
//   word schedule on byte arrays, with the S-box derived from GF(2^8)
//   inversion plus the affine map, and tracks bank contents by the
//   documented edge-by-edge latency.
module tb_key_expander;

  localparam logic [127:0] K1  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] R1  = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] R10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] Z10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  always #5 clk = ~clk;

  key_expander #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   m_sbox [256];
  logic [7:0]   m_rcon [11];
  logic [127:0] m_exp  [11];
  logic [127:0] m_bank [11];
  logic [127:0] m_rd    = '0;
  logic         m_ready = 1'b1;
  logic         m_busy  = 1'b0;
  logic         m_kv    = 1'b0;
  int           m_k     = 0;

  task automatic check_value(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic init_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    m_rcon[0] = 8'h00;
    m_rcon[1] = 8'h01;
    for (int r = 2; r <= 10; r++) m_rcon[r] = gf_mul(m_rcon[r-1], 8'h02);
    for (int i = 0; i < 11; i++) m_bank[i] = '0;
  endtask

  // FIPS-197 word expansion; word c of round key r lives at bits [32c+31:32c].
  task automatic build_schedule(input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] t0, t1, t2, t3, s0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      t0 = w[i-1][0]; t1 = w[i-1][1]; t2 = w[i-1][2]; t3 = w[i-1][3];
      if (i % 4 == 0) begin
        s0 = t0;
        t0 = m_sbox[t1] ^ m_rcon[i/4];
        t1 = m_sbox[t2];
        t2 = m_sbox[t3];
        t3 = m_sbox[s0];
      end
      w[i][0] = w[i-4][0] ^ t0;
      w[i][1] = w[i-4][1] ^ t1;
      w[i][2] = w[i-4][2] ^ t2;
      w[i][3] = w[i-4][3] ^ t3;
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          m_exp[r][8*(4*c+j) +: 8] = w[4*r+c][j];
  endtask

  // One clock: predict from pre-edge inputs, advance the reference, then
  // compare every output #1 after the edge.
  task automatic cycle();
    logic [127:0] rd_exp;
    logic         acc;
    rd_exp = (int'(rd_idx) <= 10) ? m_bank[int'(rd_idx)] : '0;
    acc    = key_valid && m_ready && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 11; i++) m_bank[i] = '0;
      m_ready = 1'b1; m_busy = 1'b0; m_kv = 1'b0; m_k = 0; m_rd = '0;
    end else begin
      m_rd = rd_exp;
      if (acc) begin
        build_schedule(key_in);
        m_bank[0] = key_in;
        m_k = 0; m_ready = 1'b0; m_busy = 1'b1; m_kv = 1'b0;
        $display("load key=%h", key_in);
      end else if (m_busy) begin
        m_k++;
        m_bank[m_k] = m_exp[m_k];
        if (m_k == 10) begin
          m_ready = 1'b1; m_busy = 1'b0; m_kv = 1'b1;
        end
      end
    end
    check_value("key_ready", key_ready, m_ready);
    check_value("busy", busy, m_busy);
    check_value("keys_valid", keys_valid, m_kv);
    check_value("rd_key", rd_key, m_rd);
    if (m_busy) check_value("rcon", dut.r_rcon, m_rcon[m_k+1]);
  endtask

  task automatic read_const(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    rd_idx = idx;
    cycle();
    check_value(tag, rd_key, exp);
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    cycle();
    key_valid = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    init_tables();
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_idx = 4'd0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Known-answer expansion and readback
    load_key(K1);
    repeat (10) cycle();
    read_const(4'd0, K1, "kat_rk0");
    read_const(4'd1, R1, "kat_rk1");
    read_const(4'd10, R10, "kat_rk10");
    read_const(4'd12, 128'h0, "kat_rk12");

    // A second key offered mid-expansion must be ignored
    load_key(K1);
    repeat (3) cycle();
    key_in = rand_key(); key_valid = 1'b1;
    cycle();
    key_valid = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      cycle();
    end
    read_const(4'd1, R1, "ign_rk1");
    read_const(4'd10, R10, "ign_rk10");

    // Reset in the middle of an expansion
    load_key(rand_key());
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) read_const(4'(i), 128'h0, "rst_clear");

    // All-zero key loaded from DONE
    load_key(K1);
    repeat (10) cycle();
    load_key(128'h0);
    repeat (10) cycle();
    read_const(4'd10, Z10, "zero_rk10");

    // Random keys, random read sweep and stray key_valid
    for (int n = 0; n < 8; n++) begin
      load_key(rand_key());
      for (int c = 0; c < 24; c++) begin
        rd_idx    = 4'($urandom_range(0, 15));
        key_in    = rand_key();
        key_valid = ($urandom_range(0, 3) == 0);
        cycle();
      end
      key_valid = 1'b0;
      repeat (12) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_expander.md
Name: key_expander

Overview:
Sequential AES-128 key expansion controller.
- Accepts a 128-bit cipher key through a valid/ready handshake.
- Iterates one key_schedule round per cycle and generates rcon internally.
- Stores all 11 round keys in an internal bank.
- The round datapath reads round keys from the bank by index with a registered read port.
- Sits between the key source (host/config interface) and the cipher round pipeline.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; only 10 (AES-128) is supported; bank depth is NUM_ROUNDS+1.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
key_in  input  128  cipher key; byte i at bits [8i+7:8i]; word i at bits [32i+31:32i]
key_valid  input  1  key_in is valid; load occurs when key_valid && key_ready
key_ready  output  1  controller can accept a new key
busy  output  1  expansion in progress
keys_valid  output  1  all 11 round keys in the bank are valid for the current key
rd_idx  input  4  round key index, 0..10
rd_key  output  128  round key selected by rd_idx, registered

Behaviour:
- Reset values (synchronous, active-high):
  - State IDLE; key_ready=1, busy=0, keys_valid=0, rd_key=0.
  - All 11 bank entries cleared to 0; round counter 0; rcon register 8'h01.
- States: IDLE, EXPAND, DONE.
- IDLE:
  - key_ready=1, keys_valid=0.
  - On key_valid: bank[0]<=key_in, counter<=1, rcon<=8'h01, go to EXPAND.
- EXPAND (key_ready=0, busy=1, keys_valid=0):
  - Each cycle: bank[counter] <= key_schedule(bank[counter-1], {24'h0, rcon}).
  - Then counter++ and rcon <= xtime(rcon), where xtime = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), truncated to 8 bits.
  - Exactly one key_schedule instance, fed from a 128-bit "previous key" register (not a 11:1 mux) so its input is a flop.
  - When counter==10 is written, go to DONE.
- DONE: key_ready=1, busy=0, keys_valid=1. On key_valid: same load as in IDLE, keys_valid drops to 0 the next cycle, go to EXPAND.
- Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- Latency:
  - Key accepted at edge T0 writes bank[0].
  - Edges T1..T10 write bank[1]..bank[10].
  - keys_valid, key_ready go 1 and busy goes 0 after edge T10.
  - Accept-to-keys_valid latency is therefore 10 cycles.
- key_valid while key_ready=0 (during EXPAND) is ignored: no load, no queuing, no effect on the expansion in progress.
- Read port:
  - rd_key <= bank[rd_idx] every cycle, 1-cycle latency, independent of state.
  - rd_idx 11..15 returns 128'h0.
  - Same-cycle read of the entry being written returns the old value; the new value is visible one cycle later.
  - Reads during EXPAND are legal but not guaranteed coherent; consumers must gate on keys_valid.
- Reset asserted mid-expansion: abort immediately; next cycle all outputs and the bank hold their reset values.
- Reset has priority over key_valid in the same cycle.

Test Plan:
1. Reset, then key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b with key_valid=1 for one cycle -> busy high for exactly 10 cycles; keys_valid=1 on the 10th cycle after acceptance; rd_idx=0 gives rd_key=128'h3c4fcf098815f7aba6d2ae2816157e2b one cycle later.
2. After case 1, read back the expanded keys -> rd_idx=1 gives 128'h05766c2a3939a323b12c548817fefaa0; rd_idx=10 gives 128'ha60c63b6c80c3fe18925eec9a8f914d0; rd_idx=12 gives 128'h0.
3. Drive key_valid=1 with a different key at cycle 4 of an expansion -> ignored: key_ready=0, and the final bank matches case 2 exactly.
4. Assert rst at cycle 5 of an expansion -> next cycle: key_ready=1, busy=0, keys_valid=0; rd_idx=0..10 all read 0.
5. In DONE, load key_in=128'h0 -> keys_valid drops next cycle and rises again 10 cycles after acceptance; rd_idx=10 gives 128'h8e188f6fcf51e92311e2923ecb5befb4 (FIPS all-zero-key round 10, byte-reversed).
6. Sweep rd_idx each cycle during and after expansion -> rd_key always equals the bank entry one cycle delayed; rcon observed at the key_schedule input steps through 01..36 in order.
